// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: two-port round-robin read-modify-write sequencer for a small CSR file
// Ports: clk, rst (async, active-low); per port p in {0,1}: reqp, opp (00 rd/01 wr/10 set/11 clr),
//   addrp, wdatap in; gntp, donep one-cycle pulses out; rdata/err valid with done; busy; csr_out flat.
module csr_access_ctrl #(
  parameter int NUM_CSR = 4,
  parameter int WIDTH = 4,
  parameter int ADDR_W = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = 'hF,
  parameter logic [NUM_CSR-1:0] RO_MASK = 'b0001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic [1:0]               op0,
  input  logic [ADDR_W-1:0]        addr0,
  input  logic [WIDTH-1:0]         wdata0,
  output logic                     gnt0,
  output logic                     done0,
  input  logic                     req1,
  input  logic [1:0]               op1,
  input  logic [ADDR_W-1:0]        addr1,
  input  logic [WIDTH-1:0]         wdata1,
  output logic                     gnt1,
  output logic                     done1,
  output logic [WIDTH-1:0]         rdata,
  output logic                     err,
  output logic                     busy,
  output logic [NUM_CSR*WIDTH-1:0] csr_out
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state_q;
  logic ptr_q, port_q, flag_q, pick1, in_rng;
  logic [1:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q, old_q, new_d;
  logic [WIDTH-1:0] csr_q [NUM_CSR];
  // port 1 wins when it is the only requester or the pointer names it
  always_comb begin
    pick1 = req1 & (~req0 | ptr_q);
    in_rng = 32'(addr_q) < NUM_CSR;
    new_d = op_q == 2'b01 ? wdata_q : op_q == 2'b10 ? old_q | wdata_q : old_q & ~wdata_q;
  end
  assign busy = state_q != IDLE;
  for (genvar i = 0; i < NUM_CSR; i++) begin : g_out
    assign csr_out[i*WIDTH +: WIDTH] = csr_q[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      port_q <= 1'b0;
      flag_q <= 1'b0;
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      old_q <= '0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
      for (int i = 0; i < NUM_CSR; i++) csr_q[i] <= RESET_VAL;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
      case (state_q)
        IDLE: if (req0 | req1) begin
          state_q <= READ;
          port_q <= pick1;
          ptr_q <= ~pick1;
          gnt0 <= ~pick1;
          gnt1 <= pick1;
          op_q <= pick1 ? op1 : op0;
          addr_q <= pick1 ? addr1 : addr0;
          wdata_q <= pick1 ? wdata1 : wdata0;
        end
        READ: begin
          old_q <= in_rng ? csr_q[addr_q] : '0;
          // out-of-range always errors; read-only only errors on a modifying op
          flag_q <= ~in_rng | (RO_MASK[addr_q] & |op_q);
          state_q <= WRITE;
        end
        WRITE: begin
          if (|op_q && !flag_q) csr_q[addr_q] <= new_d;
          state_q <= RESP;
        end
        default: begin
          done0 <= ~port_q;
          done1 <= port_q;
          rdata <= old_q;
          err <= flag_q;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed self-checking bench for csr_access_ctrl
module tb_csr_access_ctrl;
  logic clk = 0, rst = 0;
  logic req0 = 0, req1 = 0;
  logic [1:0] op0 = 0, op1 = 0, addr0 = 0, addr1 = 0;
  logic [3:0] wdata0 = 0, wdata1 = 0, rdata;
  logic gnt0, gnt1, done0, done1, err, busy;
  logic [15:0] csr_out;
  int vecs = 0, errs = 0, cyc = 0;
  csr_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .err(err), .busy(busy), .csr_out(csr_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic access(input bit p, input logic [1:0] op, input logic [1:0] a, input logic [3:0] d, output bit ok);
    ok = 0;
    if (p) begin req1 = 1; op1 = op; addr1 = a; wdata1 = d; end
    else begin req0 = 1; op0 = op; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = p ? gnt1 : gnt0;
    end
    req0 = 0;
    req1 = 0;
    if (ok) repeat (3) step();
  endtask
  task automatic test_reset();
    bit any;
    rst = 0;
    repeat (2) step();
    rst = 1;
    any = 0;
    repeat (4) begin
      step();
      any |= gnt0 | gnt1 | done0 | done1 | busy;
    end
    vecs++; if (csr_out !== 16'hFFFF) begin errs++; $display("FAIL reset_csr got %h want ffff", csr_out); end
    vecs++; if (any !== 1'b0) begin errs++; $display("FAIL reset_idle got activity %b want 0", any); end
    vecs++; if ({rdata, err} !== 5'h0) begin errs++; $display("FAIL reset_resp got %h/%b want 0/0", rdata, err); end
  endtask
  task automatic test_write();
    bit ok;
    access(0, 2'b01, 2'd2, 4'h5, ok);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL wr_gnt got no gnt0 want gnt0"); end
    vecs++; if ({done0, done1} !== 2'b10) begin errs++; $display("FAIL wr_done got %b want 10", {done0, done1}); end
    vecs++; if (rdata !== 4'hF || err !== 1'b0) begin errs++; $display("FAIL wr_resp got %h/%b want f/0", rdata, err); end
    vecs++; if (csr_out[11:8] !== 4'h5) begin errs++; $display("FAIL wr_csr2 got %h want 5", csr_out[11:8]); end
    step();
    vecs++; if ({done0, busy} !== 2'b00) begin errs++; $display("FAIL wr_pulse got %b want 00", {done0, busy}); end
  endtask
  task automatic test_set_clear();
    bit ok;
    access(1, 2'b11, 2'd3, 4'h3, ok);
    vecs++; if (!ok || done1 !== 1'b1 || rdata !== 4'hF || err !== 1'b0) begin errs++; $display("FAIL clr_resp got %b%b/%h/%b want 11/f/0", ok, done1, rdata, err); end
    vecs++; if (csr_out[15:12] !== 4'hC) begin errs++; $display("FAIL clr_csr3 got %h want c", csr_out[15:12]); end
    access(1, 2'b10, 2'd3, 4'h1, ok);
    vecs++; if (!ok || done1 !== 1'b1 || rdata !== 4'hC || err !== 1'b0) begin errs++; $display("FAIL set_resp got %b%b/%h/%b want 11/c/0", ok, done1, rdata, err); end
    vecs++; if (csr_out[15:12] !== 4'hD) begin errs++; $display("FAIL set_csr3 got %h want d", csr_out[15:12]); end
    access(0, 2'b10, 2'd3, 4'h1, ok);
    vecs++; if (!ok || rdata !== 4'hD || err !== 1'b0 || csr_out[15:12] !== 4'hD) begin errs++; $display("FAIL set_same got %h/%b/%h want d/0/d", rdata, err, csr_out[15:12]); end
  endtask
  task automatic test_ro();
    bit ok;
    access(0, 2'b01, 2'd0, 4'h0, ok);
    vecs++; if (!ok || done0 !== 1'b1 || err !== 1'b1 || rdata !== 4'hF) begin errs++; $display("FAIL ro_wr got %b%b/%b/%h want 11/1/f", ok, done0, err, rdata); end
    vecs++; if (csr_out[3:0] !== 4'hF) begin errs++; $display("FAIL ro_csr0 got %h want f", csr_out[3:0]); end
    access(1, 2'b00, 2'd0, 4'h0, ok);
    vecs++; if (!ok || done1 !== 1'b1 || err !== 1'b0 || rdata !== 4'hF) begin errs++; $display("FAIL ro_rd got %b%b/%b/%h want 11/0/f", ok, done1, err, rdata); end
  endtask
  task automatic test_back_to_back();
    int gc[8], gp[8], dc[8], dp[8], dr[8], ng, nd;
    ng = 0;
    nd = 0;
    rst = 0;
    req0 = 1; op0 = 2'b00; addr0 = 2'd1;
    req1 = 1; op1 = 2'b00; addr1 = 2'd2;
    #2 rst = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      if ((gnt0 | gnt1) && ng < 8) begin gc[ng] = cyc; gp[ng] = int'(gnt1); ng++; end
      if ((done0 | done1) && nd < 8) begin dc[nd] = cyc; dp[nd] = int'(done1); dr[nd] = int'({err, rdata}); nd++; end
    end
    req0 = 0;
    req1 = 0;
    vecs++; if (ng !== 4 || nd !== 4) begin errs++; $display("FAIL b2b_count got %0d gnt %0d done want 4 4", ng, nd); end
    for (int k = 0; k < 4; k++) begin
      if (k < ng && k < nd) begin
        vecs++;
        if (gp[k] != k % 2 || gc[k] - gc[0] != 4 * k || dp[k] != gp[k] || dc[k] != gc[k] + 3 || dr[k] != 'hF) begin
          errs++;
          $display("FAIL b2b_%0d got port %0d at +%0d done port %0d at +%0d resp %h want port %0d at +%0d done +3 resp f",
                   k, gp[k], gc[k] - gc[0], dp[k], dc[k] - gc[k], dr[k], k % 2, 4 * k);
        end
      end
    end
    repeat (4) step();
  endtask
  task automatic test_reset_abort();
    bit ok, any;
    ok = 0;
    req1 = 1; op1 = 2'b01; addr1 = 2'd2; wdata1 = 4'h0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = gnt1;
    end
    req1 = 0;
    rst = 0;
    #1;
    vecs++; if (!ok || busy !== 1'b0 || gnt1 !== 1'b0) begin errs++; $display("FAIL abort_async got gnt_seen %b busy %b gnt1 %b want 1 0 0", ok, busy, gnt1); end
    vecs++; if (csr_out !== 16'hFFFF) begin errs++; $display("FAIL abort_csr got %h want ffff", csr_out); end
    #2 rst = 1;
    any = 0;
    repeat (6) begin
      step();
      any |= done0 | done1;
    end
    vecs++; if (any !== 1'b0 || csr_out !== 16'hFFFF) begin errs++; $display("FAIL abort_nodone got done %b csr %h want 0 ffff", any, csr_out); end
    access(1, 2'b01, 2'd2, 4'h0, ok);
    vecs++; if (!ok || done1 !== 1'b1 || rdata !== 4'hF || err !== 1'b0 || csr_out[11:8] !== 4'h0) begin errs++; $display("FAIL abort_retry got %b%b/%h/%b/%h want 11/f/0/0", ok, done1, rdata, err, csr_out[11:8]); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_set_clear();
    test_ro();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
